boundary_scan_register: RTL and testbench
=========================================

Name: boundary_scan_register

Overview:
- Boundary-scan test data register (BSR) for the JTAG test logic. Sits beside the bypass register, downstream of the TAP FSM and IR decoder, and feeds the TDO control box.
- Captures pin and core values, shifts them between TDI and SO_BSR_OUT, and holds update values.
- Under EXTEST it drives the device pins from its update stage. Under INTEST it drives the core inputs from its update stage.
- Cell order from TDI to SO_BSR_OUT: N_IN input cells, then N_OUT output cells, then 1 output-enable control cell. Chain length L = N_IN + N_OUT + 1.

Parameters:
- N_IN, 4, number of input-pin cells (cells 0..N_IN-1).
- N_OUT, 3, number of output-pin cells (cells N_IN..N_IN+N_OUT-1).

Ports:
- TCK  input  1  test clock; all state changes on its rising edge.
- TRST_N  input  1  asynchronous active-low reset.
- TDI  input  1  serial data in; enters cell 0.
- bsr_select  input  1  from IR decoder; BSR is the selected data register (SAMPLE/PRELOAD, EXTEST, INTEST).
- extest  input  1  from IR decoder; EXTEST instruction active.
- intest  input  1  from IR decoder; INTEST instruction active.
- Capture_DR  input  1  TAP in Capture-DR.
- Shift_DR  input  1  TAP in Shift-DR.
- Update_DR  input  1  TAP in Update-DR.
- PIN_IN  input  N_IN  device input pads.
- CORE_IN  output  N_IN  to core: PIN_IN, or the update value under INTEST.
- CORE_OUT  input  N_OUT  core output data.
- CORE_OE  input  1  core output enable.
- PIN_OUT  output  N_OUT  to output pads.
- PIN_OE  output  1  pad output enable.
- SO_BSR_OUT  output  1  serial out = shift-stage cell L-1; goes to the TDO control box.

Behaviour:
- Storage:
  - shift stage sh[L-1:0] and update stage up[L-1:0].
  - TRST_N low clears both to all-zero immediately, regardless of TCK.
  - After release, both hold until the next qualifying rising edge.
- Qualifier: sh and up change only when bsr_select=1. With bsr_select=0, Capture_DR, Shift_DR and Update_DR are ignored and sh/up hold.
- Capture (priority 1): on a rising edge with Capture_DR=1, sh loads in parallel:
  - input cells i: PIN_IN[i];
  - output cells: CORE_OUT;
  - control cell: CORE_OE.
- Shift (priority 2): on a rising edge with Shift_DR=1 and Capture_DR=0:
  - sh[0] <= TDI;
  - sh[k] <= sh[k-1] for k = 1..L-1.
  - The bit TDI presents at edge n appears on SO_BSR_OUT after edge n+L-1 (L edges to traverse).
- Update (priority 3): on a rising edge with Update_DR=1 and no capture or shift, up <= sh.
- Simultaneous strobes (illegal from the TAP): Capture beats Shift beats Update; only one action per edge.
- SO_BSR_OUT is combinational from sh[L-1]. Reset value 0. It is valid whenever it is selected; gating is done in the TDO control box.
- Pin/core muxes (combinational):
  - PIN_OUT = extest ? up[output cells] : CORE_OUT.
  - PIN_OE = extest ? up[L-1] : CORE_OE.
  - CORE_IN = intest ? up[input cells] : PIN_IN.
  - The mux select follows extest/intest immediately; no clock delay.
- extest and intest both high (illegal): both overrides apply independently.
- Reset while EXTEST is active: up clears to 0, so PIN_OUT=0 and PIN_OE=0 until the next update.
- SAMPLE/PRELOAD (bsr_select=1, extest=0, intest=0): capture, shift and update all operate, but no output is overridden. Preloaded up values take effect the instant extest rises.
- Partial shifts (fewer or more than L bits) are not detected; the update stage loads whatever sh holds.

Test Plan:
- Reset: TRST_N low mid-shift with sh partially loaded -> SO_BSR_OUT=0, up=0; with extest=1, PIN_OUT=3'b000 and PIN_OE=0 while reset is low and after release.
- SAMPLE: PIN_IN=4'b1010, CORE_OUT=3'b110, CORE_OE=1; capture, then 8 shifts with TDI=0 -> SO_BSR_OUT sequence, first bit first, is 1,1,1,0,1,0,1,0 (control cell, output cells 6..4, input cells 3..0 in sh order); PIN_OUT keeps following CORE_OUT.
- PRELOAD then EXTEST: shift in 8 bits so that sh = {ctl=1, out=3'b101, in=4'b0000}; update; raise extest -> PIN_OUT=3'b101 and PIN_OE=1 while CORE_OUT=3'b010 and CORE_OE=0.
- INTEST: update input cells to 4'b0110, intest=1, PIN_IN=4'b1001 -> CORE_IN=4'b0110; drop intest -> CORE_IN=4'b1001 in the same cycle.
- Deselect: bsr_select=0 with Capture_DR, then Shift_DR ×8 with TDI=1, then Update_DR -> sh and up are unchanged and SO_BSR_OUT holds its prior value.
- Latency and priority: a single 1 on TDI followed by zeros -> SO_BSR_OUT goes 1 exactly after the 8th shift edge. Capture_DR and Shift_DR both asserted -> capture occurs and no shift.

Source files
------------

// File: rtl/boundary_scan_register.sv
// Boundary-scan data register: capture/shift stage plus update stage, with
// EXTEST pin muxes and INTEST core-input muxes.
module boundary_scan_register #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3
) (
    input  logic             TCK,
    input  logic             TRST_N,
    input  logic             TDI,
    input  logic             bsr_select,
    input  logic             extest,
    input  logic             intest,
    input  logic             Capture_DR,
    input  logic             Shift_DR,
    input  logic             Update_DR,
    input  logic [N_IN-1:0]  PIN_IN,
    output logic [N_IN-1:0]  CORE_IN,
    input  logic [N_OUT-1:0] CORE_OUT,
    input  logic             CORE_OE,
    output logic [N_OUT-1:0] PIN_OUT,
    output logic             PIN_OE,
    output logic             SO_BSR_OUT
);

    localparam int L = N_IN + N_OUT + 1;

    logic [L-1:0] sh;
    logic [L-1:0] up;
    logic [L-1:0] cap_val;

    // Chain order from TDI: input cells, output cells, then the enable cell.
    assign cap_val = {CORE_OE, CORE_OUT, PIN_IN};

    // Strobes are mutually exclusive from the TAP; if they collide,
    // capture wins over shift, which wins over update.
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            sh <= '0;
            up <= '0;
        end else if (bsr_select) begin
            if (Capture_DR) begin
                sh <= cap_val;
            end else if (Shift_DR) begin
                sh <= {sh[L-2:0], TDI};
            end else if (Update_DR) begin
                up <= sh;
            end
        end
    end

    assign SO_BSR_OUT = sh[L-1];
    assign PIN_OUT    = extest ? up[N_IN+N_OUT-1:N_IN] : CORE_OUT;
    assign PIN_OE     = extest ? up[L-1] : CORE_OE;
    assign CORE_IN    = intest ? up[N_IN-1:0] : PIN_IN;

endmodule

// File: tb/tb_boundary_scan_register.sv
// Directed bench for boundary_scan_register: a vector table for the
// SAMPLE / PRELOAD / EXTEST / INTEST flow plus hand-written corner sequences.
module tb_boundary_scan_register;

    logic       TCK;
    logic       TRST_N;
    logic       TDI;
    logic       bsr_select;
    logic       extest;
    logic       intest;
    logic       Capture_DR;
    logic       Shift_DR;
    logic       Update_DR;
    logic [3:0] PIN_IN;
    logic [3:0] CORE_IN;
    logic [2:0] CORE_OUT;
    logic       CORE_OE;
    logic [2:0] PIN_OUT;
    logic       PIN_OE;
    logic       SO_BSR_OUT;

    int checks   = 0;
    int failures = 0;

    boundary_scan_register #(.N_IN(4), .N_OUT(3)) dut (
        .TCK        (TCK),
        .TRST_N     (TRST_N),
        .TDI        (TDI),
        .bsr_select (bsr_select),
        .extest     (extest),
        .intest     (intest),
        .Capture_DR (Capture_DR),
        .Shift_DR   (Shift_DR),
        .Update_DR  (Update_DR),
        .PIN_IN     (PIN_IN),
        .CORE_IN    (CORE_IN),
        .CORE_OUT   (CORE_OUT),
        .CORE_OE    (CORE_OE),
        .PIN_OUT    (PIN_OUT),
        .PIN_OE     (PIN_OE),
        .SO_BSR_OUT (SO_BSR_OUT)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       sel, cap, shf, upd, tdi, ext, itst;
        logic [3:0] pin_in;
        logic [2:0] core_out;
        logic       core_oe;
        logic       so;
        logic [2:0] pout;
        logic       poe;
        logic [3:0] cin;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic sel, logic cap, logic shf, logic upd, logic tdi,
                                logic ext, logic itst, logic [3:0] pin_in,
                                logic [2:0] core_out, logic core_oe, logic so,
                                logic [2:0] pout, logic poe, logic [3:0] cin);
        vec_t v;
        v.sel = sel; v.cap = cap; v.shf = shf; v.upd = upd; v.tdi = tdi;
        v.ext = ext; v.itst = itst; v.pin_in = pin_in; v.core_out = core_out;
        v.core_oe = core_oe; v.so = so; v.pout = pout; v.poe = poe; v.cin = cin;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic cap, input logic shf,
                         input logic upd, input logic tdi);
        bsr_select = sel;
        Capture_DR = cap;
        Shift_DR   = shf;
        Update_DR  = upd;
        TDI        = tdi;
    endtask

    // One TCK edge with the given strobes; outputs sampled 1 time unit later.
    task automatic clk_step(input logic sel, input logic cap, input logic shf,
                            input logic upd, input logic tdi);
        @(negedge TCK);
        drive(sel, cap, shf, upd, tdi);
        @(posedge TCK);
        #1;
    endtask

    logic [7:0] so_sample;
    logic [7:0] pre_bits;
    logic [7:0] so_pre;
    logic [7:0] int_bits;
    logic [7:0] so_int;
    logic [7:0] sh_hold;

    initial begin
        TRST_N = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        extest   = 1'b0;
        intest   = 1'b0;
        PIN_IN   = 4'b0000;
        CORE_OUT = 3'b000;
        CORE_OE  = 1'b0;

        // Reset state
        #12;
        check("reset_so", {7'd0, SO_BSR_OUT}, 8'd0);
        extest = 1'b1;
        intest = 1'b1;
        #1;
        check("reset_pin_out", {5'd0, PIN_OUT}, 8'd0);
        check("reset_pin_oe", {7'd0, PIN_OE}, 8'd0);
        check("reset_core_in", {4'd0, CORE_IN}, 8'd0);
        extest = 1'b0;
        intest = 1'b0;
        @(negedge TCK);
        TRST_N = 1'b1;

        // SAMPLE: capture, then 8 shifts of zeros
        so_sample = 8'b11010100;
        vecs.push_back(mk(1,1,0,0,0, 0,0, 4'b1010, 3'b110, 1, 1, 3'b110, 1, 4'b1010));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1,0,1,0,0, 0,0, 4'b1010, 3'b110, 1, so_sample[7-k],
                              3'b110, 1, 4'b1010));
        // PRELOAD sh = {1, 101, 0000}, update, then raise extest
        pre_bits = 8'b11010000;
        so_pre   = 8'b00000001;
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1,0,1,0,pre_bits[7-k], 0,0, 4'b1010, 3'b010, 0, so_pre[7-k],
                              3'b010, 0, 4'b1010));
        vecs.push_back(mk(1,0,0,1,0, 0,0, 4'b1010, 3'b010, 0, 1, 3'b010, 0, 4'b1010));
        vecs.push_back(mk(1,0,0,0,0, 1,0, 4'b1010, 3'b010, 0, 1, 3'b101, 1, 4'b1010));
        // INTEST: load input cells with 0110, update, intest on/off
        int_bits = 8'b00000110;
        so_int   = 8'b10100000;
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1,0,1,0,int_bits[7-k], 0,0, 4'b1001, 3'b010, 0, so_int[7-k],
                              3'b010, 0, 4'b1001));
        vecs.push_back(mk(1,0,0,1,0, 0,1, 4'b1001, 3'b010, 0, 0, 3'b010, 0, 4'b0110));
        vecs.push_back(mk(1,0,0,0,0, 0,0, 4'b1001, 3'b010, 0, 0, 3'b010, 0, 4'b1001));
        vecs.push_back(mk(1,0,0,0,0, 1,1, 4'b1001, 3'b010, 0, 0, 3'b000, 0, 4'b0110));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge TCK);
            drive(vecs[i].sel, vecs[i].cap, vecs[i].shf, vecs[i].upd, vecs[i].tdi);
            extest   = vecs[i].ext;
            intest   = vecs[i].itst;
            PIN_IN   = vecs[i].pin_in;
            CORE_OUT = vecs[i].core_out;
            CORE_OE  = vecs[i].core_oe;
            @(posedge TCK);
            #1;
            check($sformatf("vec%0d_so", i), {7'd0, SO_BSR_OUT}, {7'd0, vecs[i].so});
            check($sformatf("vec%0d_pin_out", i), {5'd0, PIN_OUT}, {5'd0, vecs[i].pout});
            check($sformatf("vec%0d_pin_oe", i), {7'd0, PIN_OE}, {7'd0, vecs[i].poe});
            check($sformatf("vec%0d_core_in", i), {4'd0, CORE_IN}, {4'd0, vecs[i].cin});
        end

        // Core-input mux follows intest with no clock in between
        @(negedge TCK);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        extest = 1'b0;
        intest = 1'b1;
        #1;
        check("intest_on_core_in", {4'd0, CORE_IN}, 8'h06);
        intest = 1'b0;
        #1;
        check("intest_off_core_in", {4'd0, CORE_IN}, 8'h09);

        // Deselected: strobes ignored (sh = up = 0000_0110 here)
        PIN_IN   = 4'b1111;
        CORE_OUT = 3'b111;
        CORE_OE  = 1'b1;
        clk_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("desel_cap_so", {7'd0, SO_BSR_OUT}, 8'd0);
        for (int k = 0; k < 8; k++) begin
            clk_step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            check($sformatf("desel_shift%0d_so", k), {7'd0, SO_BSR_OUT}, 8'd0);
        end
        clk_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        extest = 1'b1;
        intest = 1'b1;
        #1;
        check("desel_up_pin_out", {5'd0, PIN_OUT}, 8'd0);
        check("desel_up_pin_oe", {7'd0, PIN_OE}, 8'd0);
        check("desel_up_core_in", {4'd0, CORE_IN}, 8'h06);
        extest = 1'b0;
        intest = 1'b0;
        // Shift sh out to confirm it held 0000_0110
        sh_hold = 8'b00000110;
        for (int k = 0; k < 8; k++) begin
            @(negedge TCK);
            check($sformatf("desel_sh_bit%0d", 7 - k), {7'd0, SO_BSR_OUT}, {7'd0, sh_hold[7-k]});
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            @(posedge TCK);
            #1;
        end

        // Latency: a lone 1 reaches SO after the 8th shift edge
        for (int k = 0; k < 8; k++) begin
            clk_step(1'b1, 1'b0, 1'b1, 1'b0, (k == 0) ? 1'b1 : 1'b0);
            check($sformatf("latency_edge%0d_so", k + 1), {7'd0, SO_BSR_OUT},
                  (k == 7) ? 8'd1 : 8'd0);
        end

        // Priority: capture beats shift, shift beats update
        PIN_IN   = 4'b0001;
        CORE_OUT = 3'b000;
        CORE_OE  = 1'b1;
        clk_step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("prio_cap_over_shift_so", {7'd0, SO_BSR_OUT}, 8'd1);
        extest = 1'b1;
        clk_step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("prio_shift_over_upd_so", {7'd0, SO_BSR_OUT}, 8'd0);
        check("prio_shift_over_upd_oe", {7'd0, PIN_OE}, 8'd0);
        extest = 1'b0;
        for (int k = 0; k < 6; k++) clk_step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("prio_captured_cell0", {7'd0, SO_BSR_OUT}, 8'd1);

        // Reset mid-shift with EXTEST driving preloaded ones
        for (int k = 0; k < 8; k++) clk_step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        clk_step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        extest = 1'b1;
        #1;
        check("rst_pre_pin_out", {5'd0, PIN_OUT}, 8'h07);
        check("rst_pre_pin_oe", {7'd0, PIN_OE}, 8'd1);
        for (int k = 0; k < 3; k++) clk_step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rst_pre_so", {7'd0, SO_BSR_OUT}, 8'd1);
        @(negedge TCK);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        #2;
        TRST_N = 1'b0;
        #1;
        check("rst_async_so", {7'd0, SO_BSR_OUT}, 8'd0);
        check("rst_async_pin_out", {5'd0, PIN_OUT}, 8'd0);
        check("rst_async_pin_oe", {7'd0, PIN_OE}, 8'd0);
        intest = 1'b1;
        #1;
        check("rst_async_core_in", {4'd0, CORE_IN}, 8'd0);
        @(posedge TCK);
        #1;
        check("rst_held_so", {7'd0, SO_BSR_OUT}, 8'd0);
        @(negedge TCK);
        TRST_N = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge TCK);
        #1;
        check("rst_rel_so", {7'd0, SO_BSR_OUT}, 8'd0);
        check("rst_rel_pin_out", {5'd0, PIN_OUT}, 8'd0);
        check("rst_rel_pin_oe", {7'd0, PIN_OE}, 8'd0);
        check("rst_rel_core_in", {4'd0, CORE_IN}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
